// File: rtl/sar_pkg.sv
// Shared definitions for the SAR ADC sequencer: state encoding, register
// operations, default geometry and a counter-width helper.
// Optional feature macro used elsewhere in this slice: SAR_CONT_EN.
package sar_pkg;

   localparam int SAR_NBIT = 8;   // conversion resolution in bits
   localparam int SAR_TSMP = 4;   // sample-phase length in clock cycles
   localparam int SAR_TSET = 1;   // DAC settle cycles before each decision

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SAMPLE = 2'd1,
      CONV   = 2'd2
   } sar_state_t;

   // Commands issued by the sequencer to the approximation register
   typedef enum logic [1:0] {
      REG_HOLD   = 2'd0,
      REG_CLEAR  = 2'd1,
      REG_LOAD   = 2'd2,
      REG_DECIDE = 2'd3
   } reg_op_t;

   // Width needed to hold 0..max_val, never narrower than one bit
   function automatic int cnt_width(input int max_val);
      int w;
      w = $clog2(max_val + 1);
      if (w < 1) begin
         w = 1;
      end else begin
         w = w;
      end
      return w;
   endfunction

endpackage

// File: rtl/sar_ctrl_if.sv
// Signal bundle between the SAR sequencer (master) and the analog core /
// system side (slave). The CONT line only exists when SAR_CONT_EN is defined.
interface sar_ctrl_if import sar_pkg::*; #(
   parameter int NBIT = SAR_NBIT
) ();

   logic            en;
   logic            start;
   logic            comp;
`ifdef SAR_CONT_EN
   logic            cont;
`endif
   logic            smp;
   logic            smpb;
   logic [NBIT-1:0] dac;
   logic [NBIT-1:0] dout;
   logic            valid;
   logic            busy;

   modport master (
`ifdef SAR_CONT_EN
      input  cont,
`endif
      input  en, start, comp,
      output smp, smpb, dac, dout, valid, busy
   );

   modport slave (
`ifdef SAR_CONT_EN
      output cont,
`endif
      output en, start, comp,
      input  smp, smpb, dac, dout, valid, busy
   );

endinterface

// File: rtl/sar_reg.sv
// Successive-approximation register: the NBIT trial/decided code that drives
// the capacitive DAC, plus a one-hot pointer to the bit currently on trial.
module sar_reg import sar_pkg::*; #(
   parameter int NBIT = SAR_NBIT
) (
   input  logic            ck,
   input  logic            rst,
   input  reg_op_t         op,
   input  logic            comp,
   output logic [NBIT-1:0] code,
   output logic [NBIT-1:0] decided
);

   localparam logic [NBIT-1:0] ZERO       = {NBIT{1'b0}};
   localparam logic [NBIT-1:0] MSB_ONEHOT = {1'b1, {(NBIT-1){1'b0}}};

   logic [NBIT-1:0] code_r;
   logic [NBIT-1:0] ptr_r;

   // Code with the bit under trial resolved by the current comparator output
   always_comb begin
      decided = ZERO;
      if (comp) begin
         decided = code_r | ptr_r;
      end else begin
         decided = code_r & ~ptr_r;
      end
   end

   // Apply clear / load-MSB-trial / decide-and-advance to code and pointer
   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         code_r <= ZERO;
         ptr_r  <= ZERO;
      end else begin
         case (op)
            REG_CLEAR: begin
               code_r <= ZERO;
               ptr_r  <= ZERO;
            end
            REG_LOAD: begin
               code_r <= MSB_ONEHOT;
               ptr_r  <= MSB_ONEHOT;
            end
            REG_DECIDE: begin
               code_r <= decided | {1'b0, ptr_r[NBIT-1:1]};
               ptr_r  <= {1'b0, ptr_r[NBIT-1:1]};
            end
            default: begin
               code_r <= code_r;
               ptr_r  <= ptr_r;
            end
         endcase
      end
   end

   assign code = code_r;

endmodule

// File: rtl/sar_ctrl.sv
// SAR ADC sequencer: sample phase, one trial bit per slot with settle time,
// comparator decision per bit, finished code on DOUT with a one-cycle VALID.
// Define SAR_CONT_EN to add the CONT input for back-to-back conversions
// without a new START.
module sar_ctrl import sar_pkg::*; #(
   parameter int NBIT = SAR_NBIT,
   parameter int TSMP = SAR_TSMP,
   parameter int TSET = SAR_TSET
) (
   input  logic      ck,
   input  logic      rst,
   sar_ctrl_if.master bus
);

   localparam int SCW = cnt_width(TSMP);
   localparam int STW = cnt_width(TSET);
   localparam int BIW = $clog2(NBIT);

   localparam logic [SCW-1:0]  SMP_ZERO = {SCW{1'b0}};
   localparam logic [SCW-1:0]  SMP_LAST = SCW'(TSMP - 1);
   localparam logic [STW-1:0]  SET_ZERO = {STW{1'b0}};
   localparam logic [STW-1:0]  SET_LAST = STW'(TSET);
   localparam logic [BIW-1:0]  BIT_ZERO = {BIW{1'b0}};
   localparam logic [BIW-1:0]  BIT_MSB  = BIW'(NBIT - 1);
   localparam logic [NBIT-1:0] CODE_ZERO = {NBIT{1'b0}};

   sar_state_t      state_r,   state_nxt;
   logic [SCW-1:0]  smp_cnt_r, smp_cnt_nxt;
   logic [STW-1:0]  set_cnt_r, set_cnt_nxt;
   logic [BIW-1:0]  bit_r,     bit_nxt;
   logic            smp_r,     smp_nxt;
   logic            smpb_r;
   logic            busy_r,    busy_nxt;
   logic            valid_r,   valid_nxt;
   logic [NBIT-1:0] dout_r,    dout_nxt;
   reg_op_t         reg_op_s;
   logic [NBIT-1:0] code_s;
   logic [NBIT-1:0] decided_s;
   logic            cont_s;

`ifdef SAR_CONT_EN
   assign cont_s = bus.cont;
`else
   assign cont_s = 1'b0;
`endif

   sar_reg #(.NBIT(NBIT)) u_reg (
      .ck      (ck),
      .rst     (rst),
      .op      (reg_op_s),
      .comp    (bus.comp),
      .code    (code_s),
      .decided (decided_s)
   );

   // Next state, counters, register command and next output values
   always_comb begin
      state_nxt   = state_r;
      smp_cnt_nxt = smp_cnt_r;
      set_cnt_nxt = set_cnt_r;
      bit_nxt     = bit_r;
      reg_op_s    = REG_HOLD;
      valid_nxt   = 1'b0;
      dout_nxt    = dout_r;

      if (!bus.en) begin
         // Abort: partial result is dropped, DOUT keeps the last good code
         state_nxt   = IDLE;
         smp_cnt_nxt = SMP_ZERO;
         set_cnt_nxt = SET_ZERO;
         bit_nxt     = BIT_ZERO;
         reg_op_s    = REG_CLEAR;
      end else begin
         case (state_r)
            IDLE: begin
               smp_cnt_nxt = SMP_ZERO;
               set_cnt_nxt = SET_ZERO;
               bit_nxt     = BIT_ZERO;
               reg_op_s    = REG_CLEAR;
               if (bus.start) begin
                  state_nxt = SAMPLE;
               end else begin
                  state_nxt = IDLE;
               end
            end
            SAMPLE: begin
               if (smp_cnt_r == SMP_LAST) begin
                  state_nxt   = CONV;
                  smp_cnt_nxt = SMP_ZERO;
                  set_cnt_nxt = SET_ZERO;
                  bit_nxt     = BIT_MSB;
                  reg_op_s    = REG_LOAD;
               end else begin
                  smp_cnt_nxt = smp_cnt_r + 1'b1;
               end
            end
            CONV: begin
               if (set_cnt_r == SET_LAST) begin
                  set_cnt_nxt = SET_ZERO;
                  if (bit_r == BIT_ZERO) begin
                     valid_nxt = 1'b1;
                     dout_nxt  = decided_s;
                     reg_op_s  = REG_CLEAR;
                     if (cont_s) begin
                        state_nxt = SAMPLE;
                     end else begin
                        state_nxt = IDLE;
                     end
                  end else begin
                     reg_op_s = REG_DECIDE;
                     bit_nxt  = bit_r - 1'b1;
                  end
               end else begin
                  set_cnt_nxt = set_cnt_r + 1'b1;
               end
            end
            default: begin
               state_nxt   = IDLE;
               smp_cnt_nxt = SMP_ZERO;
               set_cnt_nxt = SET_ZERO;
               bit_nxt     = BIT_ZERO;
               reg_op_s    = REG_CLEAR;
            end
         endcase
      end

      // Sample switch is closed whenever enabled and not converting
      smp_nxt  = bus.en & (state_nxt != CONV);
      busy_nxt = (state_nxt != IDLE);
   end

   // State, counters and registered outputs
   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         smp_cnt_r <= SMP_ZERO;
         set_cnt_r <= SET_ZERO;
         bit_r     <= BIT_ZERO;
         smp_r     <= 1'b0;
         smpb_r    <= 1'b1;
         busy_r    <= 1'b0;
         valid_r   <= 1'b0;
         dout_r    <= CODE_ZERO;
      end else begin
         state_r   <= state_nxt;
         smp_cnt_r <= smp_cnt_nxt;
         set_cnt_r <= set_cnt_nxt;
         bit_r     <= bit_nxt;
         smp_r     <= smp_nxt;
         smpb_r    <= ~smp_nxt;
         busy_r    <= busy_nxt;
         valid_r   <= valid_nxt;
         dout_r    <= dout_nxt;
      end
   end

   assign bus.smp   = smp_r;
   assign bus.smpb  = smpb_r;
   assign bus.dac   = code_s;
   assign bus.dout  = dout_r;
   assign bus.valid = valid_r;
   assign bus.busy  = busy_r;

endmodule

// File: tb/tb_sar_ctrl.sv
// Directed bench for sar_ctrl with an ideal comparator model and a
// scoreboard of expected conversion codes. Build with SAR_CONT_EN defined
// to also cover continuous mode.
module tb_sar_ctrl;
   import sar_pkg::*;

   logic       ck;
   logic       rst;
   logic [7:0] vin;
   int         checks;
   int         errors;
   logic [7:0] sb[$];

   sar_ctrl_if #(.NBIT(SAR_NBIT)) bus ();

   sar_ctrl #(.NBIT(SAR_NBIT), .TSMP(SAR_TSMP), .TSET(SAR_TSET)) dut (
      .ck  (ck),
      .rst (rst),
      .bus (bus)
   );

   // Ideal comparator: high when the input is at or above the DAC code
   assign bus.comp = (vin >= bus.dac);

   initial begin
      ck = 1'b0;
      forever #5 ck = ~ck;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   task automatic tick();
      @(posedge ck);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic sb_check();
      logic [7:0] e;
      chk("sb_pending", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("dout", 32'(bus.dout), 32'(e));
      end else begin
         e = 8'h00;
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_smp"},   32'(bus.smp),   32'd0);
      chk({tag, "_smpb"},  32'(bus.smpb),  32'd1);
      chk({tag, "_dac"},   32'(bus.dac),   32'd0);
      chk({tag, "_dout"},  32'(bus.dout),  32'd0);
      chk({tag, "_valid"}, 32'(bus.valid), 32'd0);
      chk({tag, "_busy"},  32'(bus.busy),  32'd0);
   endtask

   // Advance until VALID or the limit; returns edges counted
   task automatic wait_valid(input int limit, output int n);
      bit seen;
      n = 0;
      seen = 1'b0;
      while (!seen && n < limit) begin
         tick();
         n++;
         if (bus.valid === 1'b1) begin
            seen = 1'b1;
         end
      end
      chk("valid_seen", 32'(seen), 32'd1);
      if (seen) begin
         sb_check();
      end
   endtask

   // One START-pulse conversion with timing checks against edge e0
   task automatic run_conv(input logic [7:0] v, input bit toggle);
      int n;
      bit seen;
      vin = v;
      sb.push_back(v);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("smp_e0", 32'(bus.smp), 32'd1);
      chk("busy_e0", 32'(bus.busy), 32'd1);
      n = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         bus.start = (toggle && n < 19) ? n[0] : 1'b0;
         tick();
         n++;
         if (n <= 3) begin
            chk("smp_sample", 32'(bus.smp), 32'd1);
            chk("dac_sample", 32'(bus.dac), 32'd0);
         end
         if (n == 4) begin
            chk("smp_conv", 32'(bus.smp), 32'd0);
            chk("smpb_conv", 32'(bus.smpb), 32'd1);
            chk("dac_msb_trial", 32'(bus.dac), 32'h80);
         end
         if (n == 19) begin
            chk("busy_conv", 32'(bus.busy), 32'd1);
         end
         if (bus.valid === 1'b1) begin
            seen = 1'b1;
            chk("valid_edge", 32'(n), 32'd20);
            chk("busy_valid", 32'(bus.busy), 32'd0);
            chk("dac_clear", 32'(bus.dac), 32'd0);
            sb_check();
         end
      end
      chk("valid_seen", 32'(seen), 32'd1);
      bus.start = 1'b0;
      tick();
      chk("valid_pulse", 32'(bus.valid), 32'd0);
   endtask

   initial begin
      int n;
      int vcount;
      checks = 0;
      errors = 0;
      rst = 1'b1;
      vin = 8'h00;
      bus.en = 1'b0;
      bus.start = 1'b0;
`ifdef SAR_CONT_EN
      bus.cont = 1'b0;
`endif
      repeat (2) @(posedge ck);
      #1;
      chk_reset_vals("rst_init");
      rst = 1'b0;
      bus.en = 1'b1;
      tick();
      tick();

      // Ideal-comparator conversions, including START pulses while busy
      run_conv(8'hA5, 1'b0);
      run_conv(8'h00, 1'b0);
      run_conv(8'hFF, 1'b1);

      // Asynchronous reset in the middle of a conversion
      vin = 8'h77;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (8) tick();
      chk("busy_before_rst", 32'(bus.busy), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk_reset_vals("rst_mid");
      tick();
      tick();
      chk_reset_vals("rst_hold");
      rst = 1'b0;
      tick();
      tick();

      // START held high: one conversion every 21 cycles
      vin = 8'h3C;
      sb.push_back(8'h3C);
      bus.start = 1'b1;
      tick();
      wait_valid(40, n);
      chk("held_first_edge", 32'(n), 32'd20);
      sb.push_back(8'h3C);
      wait_valid(40, n);
      chk("held_period", 32'(n), 32'd21);
      bus.start = 1'b0;
      tick();
      chk("held_stop_busy", 32'(bus.busy), 32'd0);
      tick();

      // EN dropped at e10: abort, no VALID, DOUT keeps 0x3C
      vin = 8'h5A;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (9) tick();
      bus.en = 1'b0;
      tick();
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_dac", 32'(bus.dac), 32'd0);
      chk("abort_smp", 32'(bus.smp), 32'd0);
      chk("abort_smpb", 32'(bus.smpb), 32'd1);
      chk("abort_valid", 32'(bus.valid), 32'd0);
      bus.en = 1'b1;
      vcount = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (bus.valid === 1'b1) begin
            vcount++;
         end
      end
      chk("abort_no_valid", 32'(vcount), 32'd0);
      chk("abort_dout_kept", 32'(bus.dout), 32'h3C);

`ifdef SAR_CONT_EN
      // Continuous mode: 20-cycle period, then CONT=0 stops after VALID
      vin = 8'h10;
      bus.cont = 1'b1;
      sb.push_back(8'h10);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      wait_valid(40, n);
      chk("cont_first_edge", 32'(n), 32'd20);
      chk("cont_smp_restart", 32'(bus.smp), 32'd1);
      chk("cont_busy", 32'(bus.busy), 32'd1);
      vin = 8'h80;
      sb.push_back(8'h80);
      repeat (5) tick();
      bus.cont = 1'b0;
      wait_valid(40, n);
      chk("cont_period", 32'(n + 5), 32'd20);
      chk("cont_stop_busy", 32'(bus.busy), 32'd0);
      vcount = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (bus.valid === 1'b1) begin
            vcount++;
         end
      end
      chk("cont_stopped", 32'(vcount), 32'd0);
`endif

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
